// File: rtl/dmi_test_target.sv
// Multi-cycle DMI target for simulation: rotating pattern register, scratch bank and
// success counter, with programmable response latency and periodic BUSY injection.
module dmi_test_target #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 4,
    parameter int LATENCY     = 2,
    parameter int BUSY_PERIOD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dmi_req_valid,
    output logic                  dmi_req_ready,
    input  logic [ADDR_WIDTH-1:0] dmi_addr,
    input  logic [1:0]            dmi_op,
    input  logic [DATA_WIDTH-1:0] dmi_wdata,
    output logic [DATA_WIDTH-1:0] dmi_rdata,
    output logic [1:0]            dmi_resp,
    output logic                  dmi_rsp_valid
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [DATA_WIDTH-1:0] PAT      = {(DATA_WIDTH/8){8'hA5}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = ADDR_WIDTH'(NUM_REGS + 1);
    localparam int                    BW       = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;

    state_t                state, state_nxt;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rot;
    logic [DATA_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] scratch [NUM_REGS];
    logic [BW-1:0]         busy_cnt;

    logic                  accept, commit, busy_hit;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [1:0]            c_op;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  hit_rot, hit_scr, hit_cnt, wr_en;
    logic [DATA_WIDTH-1:0] rd_val, rdata_d;
    logic [1:0]            resp_d;

    // With zero latency the commit edge is the acceptance edge, so decode the live request.
    always_comb begin
        accept   = (state == IDLE) && dmi_req_valid;
        commit   = (LATENCY == 0) ? accept : ((state == WAIT) && (wait_cnt == 4'd0));
        c_addr   = (LATENCY == 0) ? dmi_addr  : addr_q;
        c_op     = (LATENCY == 0) ? dmi_op    : op_q;
        c_wdata  = (LATENCY == 0) ? dmi_wdata : wdata_q;
        busy_hit = (BUSY_PERIOD != 0) && (busy_cnt == BW'(BUSY_PERIOD - 1));
    end

    always_comb begin
        hit_rot = (c_addr == '0);
        hit_cnt = (c_addr == CNT_ADDR);
        hit_scr = !hit_rot && (32'(c_addr) <= NUM_REGS);
        rd_val  = '0;
        if (hit_rot) rd_val = rot;
        if (hit_cnt) rd_val = cnt;
        for (int i = 0; i < NUM_REGS; i++)
            if (c_addr == ADDR_WIDTH'(i + 1)) rd_val = scratch[i];
    end

    always_comb begin
        resp_d  = 2'd0;
        rdata_d = '0;
        wr_en   = 1'b0;
        if (busy_hit) begin
            resp_d = 2'd3;
        end else begin
            case (c_op)
                2'd0: ;
                2'd1: if (hit_rot || hit_scr || hit_cnt) rdata_d = rd_val;
                      else resp_d = 2'd2;
                2'd2: if (hit_rot || hit_scr) wr_en = 1'b1;
                      else resp_d = 2'd2;
                default: resp_d = 2'd2;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        dmi_req_ready = 1'b0;
        dmi_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                dmi_req_ready = 1'b1;
                if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
            end
            WAIT: if (wait_cnt == 4'd0) state_nxt = RESP;
            RESP: begin
                dmi_rsp_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            addr_q    <= '0;
            op_q      <= '0;
            wdata_q   <= '0;
            rot       <= PAT;
            cnt       <= '0;
            busy_cnt  <= '0;
            dmi_rdata <= '0;
            dmi_resp  <= 2'd0;
            for (int i = 0; i < NUM_REGS; i++)
                scratch[i] <= PAT ^ DATA_WIDTH'(i + 1);
        end else begin
            if (accept) begin
                addr_q   <= dmi_addr;
                op_q     <= dmi_op;
                wdata_q  <= dmi_wdata;
                wait_cnt <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // A committed write to ROT wins over that cycle's rotation.
            if (commit && wr_en && hit_rot) rot <= c_wdata;
            else                            rot <= {rot[DATA_WIDTH-2:0], rot[DATA_WIDTH-1]};

            if (commit) begin
                dmi_rdata <= rdata_d;
                dmi_resp  <= resp_d;
                if (resp_d == 2'd0) cnt <= cnt + 1'b1;
                for (int i = 0; i < NUM_REGS; i++)
                    if (wr_en && c_addr == ADDR_WIDTH'(i + 1)) scratch[i] <= c_wdata;
                if (BUSY_PERIOD != 0) busy_cnt <= busy_hit ? '0 : busy_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmi_test_target.sv
// Directed bench for dmi_test_target: three instances (default, BUSY injection, zero latency)
// with a scoreboard of expected responses checked when each response strobe fires.
module tb_dmi_test_target;

    localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2, RSV = 2'd3;
    localparam logic [1:0] OK = 2'd0, FAILED = 2'd2, BUSY = 2'd3;

    typedef struct {
        int          d;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          cyc;
        bit          rot;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  valid, ready, rsp_valid;
    logic [6:0]  addr_s  [3];
    logic [1:0]  op_s    [3];
    logic [31:0] wdata_s [3];
    logic [31:0] rdata   [3];
    logic [1:0]  resp    [3];

    int   total = 0, bad = 0, cyc = 0;
    int   cnt_m [3];
    exp_t sbq [$];
    exp_t e;
    logic [31:0] prev_rot;
    bit   have_rot = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmi_test_target #(.LATENCY(2), .BUSY_PERIOD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .dmi_req_valid(valid[0]), .dmi_req_ready(ready[0]),
        .dmi_addr(addr_s[0]), .dmi_op(op_s[0]), .dmi_wdata(wdata_s[0]),
        .dmi_rdata(rdata[0]), .dmi_resp(resp[0]), .dmi_rsp_valid(rsp_valid[0]));
    dmi_test_target #(.LATENCY(2), .BUSY_PERIOD(3)) u1 (
        .clk(clk), .rst_n(rst_n), .dmi_req_valid(valid[1]), .dmi_req_ready(ready[1]),
        .dmi_addr(addr_s[1]), .dmi_op(op_s[1]), .dmi_wdata(wdata_s[1]),
        .dmi_rdata(rdata[1]), .dmi_resp(resp[1]), .dmi_rsp_valid(rsp_valid[1]));
    dmi_test_target #(.LATENCY(0), .BUSY_PERIOD(0)) u2 (
        .clk(clk), .rst_n(rst_n), .dmi_req_valid(valid[2]), .dmi_req_ready(ready[2]),
        .dmi_addr(addr_s[2]), .dmi_op(op_s[2]), .dmi_wdata(wdata_s[2]),
        .dmi_rdata(rdata[2]), .dmi_resp(resp[2]), .dmi_rsp_valid(rsp_valid[2]));

    function automatic logic [31:0] rotl2(input logic [31:0] x);
        return {x[29:0], x[31:30]};
    endfunction

    // Response monitor: every strobe must match the oldest scoreboard entry.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rsp_valid[d]) begin
                total++;
                assert (sbq.size() != 0) else begin
                    bad++; $error("FAIL unexpected_rsp dut=%0d got resp=%0d rdata=%h, none expected", d, resp[d], rdata[d]);
                end
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    total++;
                    assert (d === e.d) else begin
                        bad++; $error("FAIL rsp_dut got=%0d exp=%0d", d, e.d);
                    end
                    total++;
                    assert (cyc === e.cyc) else begin
                        bad++; $error("FAIL rsp_cycle dut=%0d got=%0d exp=%0d", d, cyc, e.cyc);
                    end
                    total++;
                    assert (resp[d] === e.resp) else begin
                        bad++; $error("FAIL rsp_resp dut=%0d got=%0d exp=%0d", d, resp[d], e.resp);
                    end
                    if (e.rot) begin
                        if (have_rot) begin
                            total++;
                            assert (rdata[d] === rotl2(prev_rot)) else begin
                                bad++; $error("FAIL rot_step got=%h exp=%h", rdata[d], rotl2(prev_rot));
                            end
                        end
                        prev_rot = rdata[d];
                        have_rot = 1;
                    end else begin
                        total++;
                        assert (rdata[d] === e.rdata) else begin
                            bad++; $error("FAIL rsp_rdata dut=%0d got=%h exp=%h", d, rdata[d], e.rdata);
                        end
                    end
                end
            end
        end
    end

    task automatic req(input int d, input logic [1:0] op, input logic [6:0] a,
                       input logic [31:0] wd, input logic [1:0] er, input logic [31:0] ed,
                       input bit hold = 0, input bit push = 1, input bit isrot = 0);
        int c, n;
        @(negedge clk);
        valid[d] = 1'b1; op_s[d] = op; addr_s[d] = a; wdata_s[d] = wd;
        n = 0;
        while (!ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (ready[d] === 1'b1) else begin
            bad++; $error("FAIL accept_timeout dut=%0d got ready=%b exp=1", d, ready[d]);
        end
        c = cyc;
        @(posedge clk);
        if (push) begin
            sbq.push_back('{d, er, ed, c + ((d == 2) ? 0 : 2) + 1, isrot});
            if (er == OK) cnt_m[d]++;
        end
        if (!hold) begin
            #1 valid[d] = 1'b0;
        end
    endtask

    task automatic chk_idle(input int d);
        total++;
        assert (ready[d] === 1'b1) else begin bad++; $error("FAIL idle_ready dut=%0d got=%b exp=1", d, ready[d]); end
        total++;
        assert (rsp_valid[d] === 1'b0) else begin bad++; $error("FAIL idle_rsp_valid dut=%0d got=%b exp=0", d, rsp_valid[d]); end
        total++;
        assert (rdata[d] === 32'h0) else begin bad++; $error("FAIL idle_rdata dut=%0d got=%h exp=0", d, rdata[d]); end
        total++;
        assert (resp[d] === OK) else begin bad++; $error("FAIL idle_resp dut=%0d got=%0d exp=0", d, resp[d]); end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (sbq.size() == 0) else begin
            bad++; $error("FAIL rsp_timeout got pending=%0d exp=0", sbq.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        valid = '0;
        for (int d = 0; d < 3; d++) begin
            addr_s[d] = '0; op_s[d] = NOP; wdata_s[d] = '0; cnt_m[d] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_idle(d);

        // Reset value of SCRATCH[1], LATENCY=2 timing and ready low for three cycles.
        req(0, RD, 7'd1, 0, OK, 32'hA5A5A5A4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            assert (ready[0] === 1'b0) else begin bad++; $error("FAIL busy_ready k=%0d got=%b exp=0", k, ready[0]); end
        end
        @(negedge clk);
        total++;
        assert (ready[0] === 1'b1) else begin bad++; $error("FAIL ready_return got=%b exp=1", ready[0]); end
        wait_done();

        req(0, RD, 7'd4, 0, OK, 32'hA5A5A5A1);
        req(0, WR, 7'd2, 32'hDEADBEEF, OK, 32'h0);
        req(0, RD, 7'd2, 0, OK, 32'hDEADBEEF);
        req(0, RD, 7'd5, 0, OK, 32'(cnt_m[0]));
        req(0, WR, 7'd5, 32'h1234, FAILED, 32'h0);
        req(0, RD, 7'h40, 0, FAILED, 32'h0);
        req(0, RSV, 7'd1, 0, FAILED, 32'h0);
        req(0, RD, 7'd5, 0, OK, 32'(cnt_m[0]));
        req(0, NOP, 7'd3, 0, OK, 32'h0);
        req(0, RD, 7'd5, 0, OK, 32'(cnt_m[0]));
        wait_done();

        // BUSY every third accepted request: the third write is dropped.
        req(1, WR, 7'd1, 32'd1, OK, 32'h0);
        req(1, WR, 7'd1, 32'd2, OK, 32'h0);
        req(1, WR, 7'd1, 32'd3, BUSY, 32'h0);
        req(1, RD, 7'd1, 0, OK, 32'd2);
        req(1, RD, 7'd5, 0, OK, 32'(cnt_m[1]));
        wait_done();

        // Zero latency, valid held: one response per two cycles, ROT advances by two.
        req(2, RD, 7'd0, 0, OK, 32'h0, 1, 1, 1);
        req(2, RD, 7'd0, 0, OK, 32'h0, 1, 1, 1);
        req(2, RD, 7'd0, 0, OK, 32'h0, 1, 1, 1);
        req(2, RD, 7'd0, 0, OK, 32'h0, 0, 1, 1);
        wait_done();
        req(2, RD, 7'd5, 0, OK, 32'(cnt_m[2]));
        wait_done();

        // Reset during WAIT of a write: no response, no partial write.
        req(0, WR, 7'd3, 32'h12345678, OK, 32'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle(0);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) cnt_m[d] = 0;
        repeat (5) @(negedge clk);
        req(0, RD, 7'd3, 0, OK, 32'hA5A5A5A6);
        req(0, RD, 7'd5, 0, OK, 32'h1);
        wait_done();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
